// File: rtl/life_pkg.sv
// Shared types and constants for the life controller slice.
//
// Contents:
//   LIFE_W        width of every life / damage value
//   MAX_LIFE      starting and maximum life
//   INVUL_FRAMES  frames of invincibility after a hit that removed life
//   ANIM_STEP     largest change of a displayed bar per frame
//   REGEN_FRAMES  damage-free frames per +1 life (only used with LIFE_REGEN_EN)
//   life_state_t  match state machine encoding
//   WIN_*         winner codes reported to the game FSM
//   pick_winner   maps the two final actual lives to a winner code
package life_pkg;

  localparam int LIFE_W = 7;

  localparam logic [LIFE_W-1:0] MAX_LIFE     = 7'd100;
  localparam logic [LIFE_W-1:0] INVUL_FRAMES = 7'd60;
  localparam logic [LIFE_W-1:0] ANIM_STEP    = 7'd2;
  localparam logic [LIFE_W-1:0] REGEN_FRAMES = 7'd120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } life_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // The player whose life is still above zero wins; both at zero is a draw.
  function automatic logic [1:0] pick_winner(input logic [LIFE_W-1:0] act1,
                                             input logic [LIFE_W-1:0] act2);
    logic [1:0] win;
    win = WIN_NONE;
    if (act1 == '0 && act2 == '0) win = WIN_DRAW;
    else if (act1 == '0)          win = WIN_P2;
    else if (act2 == '0)          win = WIN_P1;
    return win;
  endfunction

endpackage

// File: rtl/life_controller_if.sv
// Bus between the game logic / renderer and the life controller.
//
// Signals:
//   frame_tick   one-cycle pulse per frame (vertical blanking)
//   new_game     one-cycle pulse restarting the match
//   hit1_req/hit1_dmg, hit2_req/hit2_dmg   damage requests per player
//   life1/life2  displayed life bars
//   invincible1/invincible2  post-hit invincibility flags
//   game_over    match finished (level)
//   winner       WIN_* code
// Modports: master drives the requests, slave is the life controller.
interface life_controller_if;
  import life_pkg::*;

  logic              frame_tick;
  logic              new_game;
  logic              hit1_req;
  logic [LIFE_W-1:0] hit1_dmg;
  logic              hit2_req;
  logic [LIFE_W-1:0] hit2_dmg;
  logic [LIFE_W-1:0] life1;
  logic [LIFE_W-1:0] life2;
  logic              invincible1;
  logic              invincible2;
  logic              game_over;
  logic [1:0]        winner;

  modport master (
    output frame_tick, new_game, hit1_req, hit1_dmg, hit2_req, hit2_dmg,
    input  life1, life2, invincible1, invincible2, game_over, winner
  );

  modport slave (
    input  frame_tick, new_game, hit1_req, hit1_dmg, hit2_req, hit2_dmg,
    output life1, life2, invincible1, invincible2, game_over, winner
  );

endinterface

// File: rtl/life_channel.sv
// One player's life bookkeeping: damage accumulator, actual and displayed
// life, invincibility counter and (optionally) a regeneration counter.
// Optional feature macro: LIFE_REGEN_EN (adds the regeneration counter).
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        restart the match (overrides everything else)
//   hit_en       hits may be captured (match in PLAY)
//   tick_en      apply a frame update this cycle
//   regen_en     regeneration allowed (match in PLAY)
//   hit_req/hit_dmg  damage request and amount
//   actual       true life (registered)
//   actual_nxt   life value that will be loaded this cycle
//   displayed    animated bar value (registered)
//   invincible   post-hit invincibility flag (registered)
module life_channel
  import life_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hit_en,
  input  logic              tick_en,
  input  logic              regen_en,
  input  logic              hit_req,
  input  logic [LIFE_W-1:0] hit_dmg,
  output logic [LIFE_W-1:0] actual,
  output logic [LIFE_W-1:0] actual_nxt,
  output logic [LIFE_W-1:0] displayed,
  output logic              invincible
);

  logic [LIFE_W-1:0] pending_q, pending_d;
  logic [LIFE_W-1:0] actual_q, actual_d;
  logic [LIFE_W-1:0] displayed_q, displayed_d;
  logic [LIFE_W-1:0] invul_cnt_q, invul_cnt_d;
  logic              invincible_q, invincible_d;
  logic [LIFE_W-1:0] pending_base;
  logic [LIFE_W:0]   pending_sum;
`ifdef LIFE_REGEN_EN
  logic [LIFE_W-1:0] regen_cnt_q, regen_cnt_d;
`else
  logic              unused_regen_en;
  assign unused_regen_en = regen_en;
`endif

  // Next-state for the whole channel. On a tick the pending register is
  // emptied first, so a hit arriving in the same cycle lands in the fresh
  // accumulator and is applied one frame later. The bar animates toward the
  // value being loaded this tick.
  always_comb begin
    pending_base = tick_en ? '0 : pending_q;
    pending_sum  = {1'b0, pending_base} + {1'b0, hit_dmg};
    pending_d    = pending_base;
    actual_d     = actual_q;
    displayed_d  = displayed_q;
    invul_cnt_d  = invul_cnt_q;
    invincible_d = invincible_q;
`ifdef LIFE_REGEN_EN
    regen_cnt_d  = regen_cnt_q;
`endif

    if (hit_en && hit_req && !invincible_q) begin
      pending_d = (pending_sum > {1'b0, MAX_LIFE}) ? MAX_LIFE
                                                   : pending_sum[LIFE_W-1:0];
    end

    if (tick_en) begin
      actual_d = (actual_q > pending_q) ? actual_q - pending_q : '0;

      if (pending_q != '0 && actual_q != '0) begin
        invul_cnt_d  = INVUL_FRAMES;
        invincible_d = 1'b1;
      end else if (invul_cnt_q != '0) begin
        invul_cnt_d = invul_cnt_q - 7'd1;
        if (invul_cnt_q == 7'd1) invincible_d = 1'b0;
      end

`ifdef LIFE_REGEN_EN
      if (pending_q != '0) begin
        regen_cnt_d = '0;
      end else if (regen_en && actual_q != '0) begin
        if (regen_cnt_q == REGEN_FRAMES - 7'd1) begin
          regen_cnt_d = '0;
          actual_d    = (actual_q == MAX_LIFE) ? MAX_LIFE : actual_q + 7'd1;
        end else begin
          regen_cnt_d = regen_cnt_q + 7'd1;
        end
      end
`endif

      if (displayed_q < actual_d) begin
        displayed_d = (actual_d - displayed_q > ANIM_STEP) ? displayed_q + ANIM_STEP
                                                          : actual_d;
      end else if (displayed_q > actual_d) begin
        displayed_d = (displayed_q - actual_d > ANIM_STEP) ? displayed_q - ANIM_STEP
                                                          : actual_d;
      end
    end

    if (clear) begin
      pending_d    = '0;
      actual_d     = MAX_LIFE;
      displayed_d  = MAX_LIFE;
      invul_cnt_d  = '0;
      invincible_d = 1'b0;
`ifdef LIFE_REGEN_EN
      regen_cnt_d  = '0;
`endif
    end
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      actual_q     <= MAX_LIFE;
      displayed_q  <= MAX_LIFE;
      invul_cnt_q  <= '0;
      invincible_q <= 1'b0;
`ifdef LIFE_REGEN_EN
      regen_cnt_q  <= '0;
`endif
    end else begin
      pending_q    <= pending_d;
      actual_q     <= actual_d;
      displayed_q  <= displayed_d;
      invul_cnt_q  <= invul_cnt_d;
      invincible_q <= invincible_d;
`ifdef LIFE_REGEN_EN
      regen_cnt_q  <= regen_cnt_d;
`endif
    end
  end

  assign actual     = actual_q;
  assign actual_nxt = actual_d;
  assign displayed  = displayed_q;
  assign invincible = invincible_q;

endmodule

// File: rtl/life_controller.sv
// Life controller top: match state machine, winner detection and one
// life_channel per player. Damage is applied once per frame so the HUD bars
// never change mid-frame.
// Optional feature macro: LIFE_REGEN_EN (slow life regeneration in PLAY).
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    life_controller_if.slave (requests in, bars/flags/result out)
module life_controller
  import life_pkg::*;
(
  input logic              clk,
  input logic              reset,
  life_controller_if.slave bus
);

  life_state_t       state_q, state_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic              hit_en, tick_en, regen_en;
  logic [LIFE_W-1:0] act1, act1_nxt, disp1;
  logic [LIFE_W-1:0] act2, act2_nxt, disp2;
  logic              inv1, inv2;

  assign hit_en   = (state_q == PLAY);
  assign regen_en = (state_q == PLAY);
  assign tick_en  = bus.frame_tick && (state_q == PLAY || state_q == DYING);

  life_channel u_ch1 (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.new_game),
    .hit_en     (hit_en),
    .tick_en    (tick_en),
    .regen_en   (regen_en),
    .hit_req    (bus.hit1_req),
    .hit_dmg    (bus.hit1_dmg),
    .actual     (act1),
    .actual_nxt (act1_nxt),
    .displayed  (disp1),
    .invincible (inv1)
  );

  life_channel u_ch2 (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.new_game),
    .hit_en     (hit_en),
    .tick_en    (tick_en),
    .regen_en   (regen_en),
    .hit_req    (bus.hit2_req),
    .hit_dmg    (bus.hit2_dmg),
    .actual     (act2),
    .actual_nxt (act2_nxt),
    .displayed  (disp2),
    .invincible (inv2)
  );

  // Match FSM. PLAY drops to DYING on the tick that empties a life bar;
  // DYING waits for both bars to finish animating before declaring the
  // result, so the HUD shows the final value when game_over rises.
  always_comb begin
    state_d     = state_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (bus.new_game) begin
      state_d     = PLAY;
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.frame_tick && (act1_nxt == '0 || act2_nxt == '0)) state_d = DYING;
        end
        DYING: begin
          if (bus.frame_tick && disp1 == act1 && disp2 == act2) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = pick_winner(act1, act2);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.life1       = disp1;
  assign bus.life2       = disp2;
  assign bus.invincible1 = inv1;
  assign bus.invincible2 = inv2;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed testbench for life_controller. Inputs change and outputs are
// sampled on the falling clock edge; every expected value is hand-computed.
// The regeneration check is only built when LIFE_REGEN_EN is defined.
module tb_life_controller;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  int   ticksTaken;

  always #5 clk = ~clk;

  life_controller_if bus ();

  life_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Drive one cycle of requests starting at a falling edge, then idle them.
  task automatic applyStimulus(input bit tick, input bit ng,
                               input bit h1, input int d1,
                               input bit h2, input int d2);
    bus.frame_tick = tick;
    bus.new_game   = ng;
    bus.hit1_req   = h1;
    bus.hit1_dmg   = 7'(d1);
    bus.hit2_req   = h2;
    bus.hit2_dmg   = 7'(d2);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.new_game   = 1'b0;
    bus.hit1_req   = 1'b0;
    bus.hit1_dmg   = '0;
    bus.hit2_req   = 1'b0;
    bus.hit2_dmg   = '0;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.new_game   = 1'b0;
    bus.hit1_req   = 1'b0;
    bus.hit1_dmg   = '0;
    bus.hit2_req   = 1'b0;
    bus.hit2_dmg   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_life1", bus.life1, 100);
    checkOutput("rst_life2", bus.life2, 100);
    checkOutput("rst_inv1", bus.invincible1, 0);
    checkOutput("rst_game_over", bus.game_over, 0);
    checkOutput("rst_winner", bus.winner, 0);

    // Hits in IDLE are ignored
    applyStimulus(0, 0, 1, 50, 0, 0);
    tickN(1);
    checkOutput("idle_hit_life1", bus.life1, 100);

    $display("[TB] test 1: damage 30 animates over 15 ticks");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 30, 0, 0);
    checkOutput("t1_before_tick", bus.life1, 100);
    tickN(1);                                   // tick 1
    checkOutput("t1_tick1_life1", bus.life1, 98);
    checkOutput("t1_tick1_inv1", bus.invincible1, 1);
    tickN(13);                                  // tick 14
    checkOutput("t1_tick14_life1", bus.life1, 72);
    tickN(1);                                   // tick 15
    checkOutput("t1_tick15_life1", bus.life1, 70);

    $display("[TB] test 2: hit while invincible is dropped");
    applyStimulus(0, 0, 1, 20, 0, 0);
    tickN(1);                                   // tick 16
    checkOutput("t2_life1", bus.life1, 70);
    checkOutput("t2_inv1", bus.invincible1, 1);

    $display("[TB] test 3: two hits in one frame");
    applyStimulus(0, 0, 0, 0, 1, 10);
    applyStimulus(0, 0, 0, 0, 1, 15);
    tickN(1);                                   // tick 17
    checkOutput("t3_tick17_life2", bus.life2, 98);
    checkOutput("t3_tick17_inv2", bus.invincible2, 1);
    tickN(11);                                  // tick 28
    checkOutput("t3_tick28_life2", bus.life2, 76);
    tickN(1);                                   // tick 29
    checkOutput("t3_tick29_life2", bus.life2, 75);

    // Invincibility of player 1 (set at tick 1) lasts 60 ticks
    tickN(31);                                  // tick 60
    checkOutput("inv1_tick60", bus.invincible1, 1);
    tickN(1);                                   // tick 61
    checkOutput("inv1_tick61", bus.invincible1, 0);
    checkOutput("life1_tick61", bus.life1, 70);
    tickN(15);                                  // tick 76
    checkOutput("inv2_tick76", bus.invincible2, 1);
    tickN(1);                                   // tick 77
    checkOutput("inv2_tick77", bus.invincible2, 0);

    $display("[TB] test 4: hit in the tick cycle applies at the next tick");
    applyStimulus(1, 0, 0, 0, 1, 10);           // tick 78
    checkOutput("t4_tick78_life2", bus.life2, 75);
    checkOutput("t4_tick78_inv2", bus.invincible2, 0);
    tickN(1);                                   // tick 79
    checkOutput("t4_tick79_life2", bus.life2, 73);
    checkOutput("t4_tick79_inv2", bus.invincible2, 1);

    $display("[TB] test 5: saturating lethal hit, P2 wins");
    applyStimulus(0, 0, 1, 65, 0, 0);
    tickN(1);                                   // tick 80: actual1 = 5
    checkOutput("t5_tick80_life1", bus.life1, 68);
    tickN(59);                                  // tick 139
    checkOutput("t5_tick139_inv1", bus.invincible1, 1);
    checkOutput("t5_tick139_life1", bus.life1, 5);
    checkOutput("t5_tick139_life2", bus.life2, 65);
    tickN(1);                                   // tick 140
    checkOutput("t5_tick140_inv1", bus.invincible1, 0);
    applyStimulus(0, 0, 1, 40, 0, 0);
    tickN(1);                                   // tick 141: actual1 = 0, DYING
    checkOutput("t5_tick141_life1", bus.life1, 3);
    checkOutput("t5_tick141_game_over", bus.game_over, 0);
    tickN(2);                                   // tick 143
    checkOutput("t5_tick143_life1", bus.life1, 0);
    checkOutput("t5_tick143_game_over", bus.game_over, 0);
    tickN(1);                                   // tick 144: OVER
    checkOutput("t5_game_over", bus.game_over, 1);
    checkOutput("t5_winner", bus.winner, 2);

    // Frozen in OVER
    applyStimulus(1, 0, 1, 10, 1, 10);
    tickN(2);
    checkOutput("over_life2", bus.life2, 65);
    checkOutput("over_game_over", bus.game_over, 1);
    checkOutput("over_winner", bus.winner, 2);

    $display("[TB] test 6: double knockout is a draw");
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("t6_ng_life1", bus.life1, 100);
    checkOutput("t6_ng_life2", bus.life2, 100);
    checkOutput("t6_ng_game_over", bus.game_over, 0);
    checkOutput("t6_ng_winner", bus.winner, 0);
    applyStimulus(0, 0, 1, 100, 1, 100);
    ticksTaken = 0;
    while (!bus.game_over && ticksTaken < 60) begin
      tickN(1);
      ticksTaken++;
    end
    checkOutput("t6_ticks_to_over", ticksTaken, 51);
    checkOutput("t6_winner", bus.winner, 3);
    checkOutput("t6_life1", bus.life1, 0);
    checkOutput("t6_life2", bus.life2, 0);

    // new_game in OVER restores the match
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("ng_over_life1", bus.life1, 100);
    checkOutput("ng_over_life2", bus.life2, 100);
    checkOutput("ng_over_game_over", bus.game_over, 0);
    checkOutput("ng_over_winner", bus.winner, 0);

    // new_game wins over a hit and a tick in the same cycle
    applyStimulus(1, 1, 1, 50, 0, 0);
    tickN(1);
    checkOutput("prio_life1", bus.life1, 100);
    checkOutput("prio_inv1", bus.invincible1, 0);

`ifdef LIFE_REGEN_EN
    $display("[TB] regeneration");
    applyStimulus(0, 0, 1, 1, 0, 0);
    tickN(1);
    checkOutput("regen_hit_life1", bus.life1, 99);
    tickN(119);
    checkOutput("regen_119_life1", bus.life1, 99);
    tickN(1);
    checkOutput("regen_120_life1", bus.life1, 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
